accum_core: RTL and testbench
=============================

Name: accum_core

Overview:
- Parametrised multi-cycle accumulator CPU core, successor to the fixed 8-bit bus datapath.
- Data width and address width are generic. Memory is external behind a req/ready handshake, so wait states are supported.
- Adds reset, halt, conditional branches and absolute load/store.
- Sits between the board top level (LED/debug) and a RAM/ROM wrapper.

Parameters:
DATA_WIDTH, 8, accumulator/temp/memory word width; legal range 8..16.
ADDR_WIDTH, 16, address/PC width; must satisfy DATA_WIDTH < ADDR_WIDTH <= 2*DATA_WIDTH.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_WIDTH  transaction address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data; valid in the cycle mem_ready is high
mem_ready  in  1  transaction completes in any cycle with mem_req && mem_ready
acc_out  out  DATA_WIDTH  accumulator
pc_out  out  ADDR_WIDTH  program counter
flags_out  out  2  {overflow, zero}
halted  out  1  core is in HALT

Behaviour:
- Reset (async, active-high): state=FETCH, pc=RESET_PC, acc=0, temp=0, flags=0, operand=0, mem_req=0, halted=0. Reset mid-transaction abandons it; mem_req drops immediately.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - Transaction completes in the cycle where mem_req && mem_ready.
  - Back-to-back requests are allowed.
  - mem_req=0 in DECODE, EXEC_ALU and HALT.
- Instruction word = mem_rdata[7:0]: class = [7:4], alu_op = [3:0].
- Instruction classes:
  - 0x0 NOP
  - 0x1 ALU: acc <= acc op temp
  - 0x2 LDI: acc <= next word
  - 0x3 MVT: temp <= acc
  - 0x4 LD a: acc <= mem[a]
  - 0x5 ST a: mem[a] <= acc
  - 0x6 JMP a
  - 0x7 JZ a: jump if zero flag
  - 0x8 JO a: jump if overflow flag
  - 0xF HLT
  - 0x9-0xE execute as NOP.
- Address operand a = two words, low word first: a = {hi, lo} truncated to ADDR_WIDTH. PC increments by 1 per fetched word and wraps mod 2^ADDR_WIDTH.
- States and transitions:
  - FETCH: read mem[pc] -> ir; pc++ -> DECODE.
  - DECODE (1 cycle):
    - NOP/MVT complete -> FETCH.
    - ALU -> EXEC_ALU.
    - LDI -> OPLO.
    - LD/ST/JMP/JZ/JO -> OPLO.
    - HLT -> HALT.
  - OPLO: read mem[pc]; pc++.
    - LDI: acc <= rdata -> FETCH.
    - Otherwise latch lo -> OPHI.
  - OPHI: read mem[pc]; pc++; latch hi.
    - JMP, or JZ/JO with condition true: pc <= a -> FETCH.
    - JZ/JO with condition false -> FETCH.
    - LD -> EXEC_RD.
    - ST -> EXEC_WR.
  - EXEC_RD: read mem[a] -> acc -> FETCH.
  - EXEC_WR: write acc to mem[a] -> FETCH.
  - EXEC_ALU: one cycle; result and flags registered -> FETCH.
  - HALT: terminal until rst; halted=1; no requests.
- ALU (b = temp, W = DATA_WIDTH):
  - NOT = ~acc
  - OR, AND, XOR
  - ADD: overflow = carry out of bit W-1.
  - SUB = acc - temp: overflow = borrow (acc < temp, unsigned).
  - SHL/LSHR/ASHR shift by 1: overflow = bit shifted out.
  - Logic ops clear overflow.
  - zero = (result == 0) for all defined ops.
  - alu_op 0x9-0xF: acc and flags unchanged.
- Only ALU instructions update flags. LD/LDI/MVT do not.
- Latency with zero wait states:
  - NOP/MVT: 2 cycles.
  - ALU, LDI: 3 cycles.
  - JMP/JZ/JO: 4 cycles.
  - LD/ST: 5 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset mid-fetch: assert rst while mem_req=1, mem_ready=0 -> mem_req=0 same cycle; after release, first request has addr=RESET_PC=0, we=0.
- LDI/MVT/ALU program: `21 05 30 21 FB 14 F0` (LDI 5; MVT; LDI 0xFB; ADD) -> acc=0x00, flags=2'b11, then halted=1 at pc=7.
- Branching: `14` giving zero=1, then `70 10 00` (JZ 0x0010) -> next fetch addr=0x0010. With zero=0 the next fetch addr is pc+3 instead.
- Load/store with wait states, mem_ready low 2 cycles per access: `21 A5 50 00 02 40 00 02` -> write at 0x0200 data 0xA5, stable through waits; LD returns acc=0xA5; total ST time 5+2*4 cycles.
- Shifts: acc=0x81, ASHR -> acc=0xC0, overflow=1, zero=0; LSHR of 0x01 -> acc=0, flags=2'b11.
- Parameter sweep DATA_WIDTH=12, ADDR_WIDTH=20: JMP with lo=0x345, hi=0x0AB -> pc=0xAB345; PC wrap from 0xFFFFF fetches 0x00000.

Source files
------------

// File: rtl/accum_core.sv
// Multi-cycle accumulator core with a parametrised datapath and an external
// req/ready memory port; instructions are one byte, address operands two words.
module accum_core #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [1:0]            flags_out,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPLO, S_OPHI, S_EXEC_RD, S_EXEC_WR, S_EXEC_ALU, S_HALT
  } state_t;

  localparam logic [3:0] C_ALU = 4'h1;
  localparam logic [3:0] C_LDI = 4'h2;
  localparam logic [3:0] C_MVT = 4'h3;
  localparam logic [3:0] C_LD  = 4'h4;
  localparam logic [3:0] C_ST  = 4'h5;
  localparam logic [3:0] C_JMP = 4'h6;
  localparam logic [3:0] C_JZ  = 4'h7;
  localparam logic [3:0] C_JO  = 4'h8;
  localparam logic [3:0] C_HLT = 4'hF;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, addr_q;
  logic [DATA_WIDTH-1:0] acc_q, temp_q, lo_q;
  logic [7:0]            ir_q;
  logic                  ovf_q, zero_q, req_q, halted_q;

  logic [ADDR_WIDTH-1:0] pcInc_d, opAddr_d;
  logic [DATA_WIDTH-1:0] aluRes_d;
  logic [DATA_WIDTH:0]   aluSum;
  logic                  aluOvf_d, aluZero_d, aluDef, taken;

  assign pcInc_d  = pc_q + ADDR_WIDTH'(1);
  assign opAddr_d = ADDR_WIDTH'({mem_rdata, lo_q});
  assign aluSum   = {1'b0, acc_q} + {1'b0, temp_q};
  assign taken    = (ir_q[7:4] == C_JMP) ||
                    ((ir_q[7:4] == C_JZ) && zero_q) ||
                    ((ir_q[7:4] == C_JO) && ovf_q);

  // Undefined alu_op codes leave the accumulator and both flags untouched.
  always_comb begin
    aluDef   = 1'b1;
    aluOvf_d = 1'b0;
    aluRes_d = acc_q;
    case (ir_q[3:0])
      4'h0: aluRes_d = ~acc_q;
      4'h1: aluRes_d = acc_q | temp_q;
      4'h2: aluRes_d = acc_q & temp_q;
      4'h3: aluRes_d = acc_q ^ temp_q;
      4'h4: begin aluRes_d = aluSum[DATA_WIDTH-1:0]; aluOvf_d = aluSum[DATA_WIDTH]; end
      4'h5: begin aluRes_d = acc_q - temp_q; aluOvf_d = (acc_q < temp_q); end
      4'h6: begin aluRes_d = acc_q << 1; aluOvf_d = acc_q[DATA_WIDTH-1]; end
      4'h7: begin aluRes_d = acc_q >> 1; aluOvf_d = acc_q[0]; end
      4'h8: begin aluRes_d = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]}; aluOvf_d = acc_q[0]; end
      default: begin aluDef = 1'b0; aluOvf_d = ovf_q; end
    endcase
    aluZero_d = aluDef ? (aluRes_d == '0) : zero_q;
  end

  // req_q is raised on the edge entering a memory state, so fetches can run back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      acc_q    <= '0;
      temp_q   <= '0;
      lo_q     <= '0;
      addr_q   <= '0;
      ir_q     <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ready) begin
            ir_q    <= mem_rdata[7:0];
            pc_q    <= pcInc_d;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (ir_q[7:4])
            C_ALU: state_q <= S_EXEC_ALU;
            C_LDI, C_LD, C_ST, C_JMP, C_JZ, C_JO: begin
              req_q   <= 1'b1;
              state_q <= S_OPLO;
            end
            C_HLT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              if (ir_q[7:4] == C_MVT) temp_q <= acc_q;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_OPLO: begin
          if (mem_ready) begin
            pc_q <= pcInc_d;
            if (ir_q[7:4] == C_LDI) begin
              acc_q   <= mem_rdata;
              state_q <= S_FETCH;
            end else begin
              lo_q    <= mem_rdata;
              state_q <= S_OPHI;
            end
          end
        end
        S_OPHI: begin
          if (mem_ready) begin
            addr_q <= opAddr_d;
            pc_q   <= pcInc_d;
            case (ir_q[7:4])
              C_LD:    state_q <= S_EXEC_RD;
              C_ST:    state_q <= S_EXEC_WR;
              default: begin
                if (taken) pc_q <= opAddr_d;
                state_q <= S_FETCH;
              end
            endcase
          end
        end
        S_EXEC_RD: begin
          if (mem_ready) begin
            acc_q   <= mem_rdata;
            state_q <= S_FETCH;
          end
        end
        S_EXEC_WR: begin
          if (mem_ready) state_q <= S_FETCH;
        end
        S_EXEC_ALU: begin
          acc_q   <= aluRes_d;
          ovf_q   <= aluOvf_d;
          zero_q  <= aluZero_d;
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = (state_q == S_EXEC_WR);
  assign mem_addr  = ((state_q == S_EXEC_RD) || (state_q == S_EXEC_WR)) ? addr_q : pc_q;
  assign mem_wdata = acc_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign flags_out = {ovf_q, zero_q};
  assign halted    = halted_q;

endmodule

// File: tb/tb_accum_core.sv
// Scoreboarded bench: an 8/16 core with a wait-state memory and a 12/20 core
// for wide operands and PC wrap; expected bus transactions are queued up front.
module tb_accum_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, rstB;
  logic        memReqA, memWeA, memReadyA, haltedA;
  logic [15:0] memAddrA, pcA;
  logic [7:0]  memWdataA, memRdataA, accA;
  logic [1:0]  flagsA;
  logic        memReqB, memWeB, memReadyB, haltedB;
  logic [19:0] memAddrB, pcB;
  logic [11:0] memWdataB, memRdataB, accB;
  logic [1:0]  flagsB;

  accum_core #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RESET_PC(16'h0000)) dutA (
    .clk(clk), .rst(rstA), .mem_req(memReqA), .mem_we(memWeA), .mem_addr(memAddrA),
    .mem_wdata(memWdataA), .mem_rdata(memRdataA), .mem_ready(memReadyA),
    .acc_out(accA), .pc_out(pcA), .flags_out(flagsA), .halted(haltedA));

  accum_core #(.DATA_WIDTH(12), .ADDR_WIDTH(20), .RESET_PC(20'h00010)) dutB (
    .clk(clk), .rst(rstB), .mem_req(memReqB), .mem_we(memWeB), .mem_addr(memAddrB),
    .mem_wdata(memWdataB), .mem_rdata(memRdataB), .mem_ready(memReadyB),
    .acc_out(accB), .pc_out(pcB), .flags_out(flagsB), .halted(haltedB));

  logic [7:0]  memA [0:65535];
  logic [11:0] memB [0:1048575];
  int waitCfg = 0;
  int waitCntA = 0;
  int cycleCnt = 0;

  assign memReadyA = memReqA && (waitCntA >= waitCfg);
  assign memReadyB = memReqB;
  assign memRdataA = memA[memAddrA];
  assign memRdataB = memB[memAddrB];

  // Memory model: core A stalls waitCfg cycles per access, core B never stalls.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (memReqA && !memReadyA) waitCntA <= waitCntA + 1;
    else                       waitCntA <= 0;
    if (memReqA && memReadyA && memWeA) memA[memAddrA] = memWdataA;
    if (memReqB && memReadyB && memWeB) memB[memAddrB] = memWdataB;
  end

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [15:0] data;
    bit          mark;
    int          gap;
  } txn_t;

  txn_t expQ[$];
  int assertCount = 0;
  int failCount = 0;
  int refCycle = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectTxn(input bit we, input logic [19:0] addr, input logic [15:0] data,
                           input bit mark, input int gap);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.mark = mark; t.gap = gap;
    expQ.push_back(t);
  endtask

  task automatic expectReads(input logic [19:0] first, input int count);
    for (int i = 0; i < count; i++) expectTxn(1'b0, first + 20'(i), 16'h0, 1'b0, 0);
  endtask

  task automatic scoreTxn(input bit we, input logic [19:0] addr, input logic [15:0] data);
    txn_t e;
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL unexpectedTxn: got addr 0x%0h we %0d, expected no transaction", addr, we);
      return;
    end
    e = expQ.pop_front();
    checkOutput($sformatf("txnWe@%0h", e.addr), {31'h0, we}, {31'h0, e.we});
    checkOutput($sformatf("txnAddr@%0h", e.addr), {12'h0, addr}, {12'h0, e.addr});
    if (e.we) checkOutput($sformatf("txnWdata@%0h", e.addr), {16'h0, data}, {16'h0, e.data});
    if (e.mark) refCycle = cycleCnt;
    if (e.gap > 0) checkOutput($sformatf("latency@%0h", e.addr), cycleCnt - refCycle, e.gap);
  endtask

  logic        stallPrev = 1'b0;
  logic        stallWe;
  logic [15:0] stallAddr;
  logic [7:0]  stallData;

  // Monitor: scores each completing transaction and checks request hold during stalls.
  always @(negedge clk) begin
    if (memReqA && memReadyA) scoreTxn(memWeA, {4'h0, memAddrA}, {8'h0, memWdataA});
    if (memReqB && memReadyB) scoreTxn(memWeB, memAddrB, {4'h0, memWdataB});
    if (stallPrev && memReqA) begin
      checkOutput("holdAddr", {16'h0, memAddrA}, {16'h0, stallAddr});
      checkOutput("holdWe", {31'h0, memWeA}, {31'h0, stallWe});
      checkOutput("holdWdata", {24'h0, memWdataA}, {24'h0, stallData});
    end
    stallPrev <= memReqA && !memReadyA;
    stallAddr <= memAddrA;
    stallWe   <= memWeA;
    stallData <= memWdataA;
  end

  task automatic applyStimulus(input logic [7:0] prog[$]);
    rstA = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) memA[i] = 8'h00;
    foreach (prog[i]) memA[i] = prog[i];
  endtask

  task automatic waitHalted(input bit useB, input int limit);
    int n = 0;
    while (!(useB ? haltedB : haltedA) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(useB ? "haltReachedB" : "haltReachedA", {31'h0, useB ? haltedB : haltedA}, 32'h1);
  endtask

  task automatic checkFinalA(input string tag, input logic [7:0] acc, input logic [1:0] flags,
                             input logic [15:0] pc);
    checkOutput({tag, ".acc"}, {24'h0, accA}, {24'h0, acc});
    checkOutput({tag, ".flags"}, {30'h0, flagsA}, {30'h0, flags});
    checkOutput({tag, ".pc"}, {16'h0, pcA}, {16'h0, pc});
    checkOutput({tag, ".queueEmpty"}, expQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] p[$];
    int n;
    rstA = 1'b1;
    rstB = 1'b1;

    // Reset abandons a stalled fetch, then the LDI/MVT/ADD program runs.
    waitCfg = 5;
    p = '{8'h21, 8'h05, 8'h30, 8'h21, 8'hFB, 8'h14, 8'hF0};
    applyStimulus(p);
    @(negedge clk);
    checkOutput("rst.acc", {24'h0, accA}, 32'h0);
    checkOutput("rst.pc", {16'h0, pcA}, 32'h0);
    checkOutput("rst.flags", {30'h0, flagsA}, 32'h0);
    checkOutput("rst.halted", {31'h0, haltedA}, 32'h0);
    checkOutput("rst.req", {31'h0, memReqA}, 32'h0);
    rstA = 1'b0;
    n = 0;
    while (!memReqA && n < 10) begin @(negedge clk); n++; end
    checkOutput("reqAfterReset", {31'h0, memReqA}, 32'h1);
    @(negedge clk);
    rstA = 1'b1;
    #1;
    checkOutput("reqDropsOnReset", {31'h0, memReqA}, 32'h0);
    waitCfg = 0;
    expectReads(20'h0, 5);
    expectTxn(1'b0, 20'h5, 16'h0, 1'b1, 0);
    expectTxn(1'b0, 20'h6, 16'h0, 1'b0, 3);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 200);
    checkFinalA("prog1", 8'h00, 2'b11, 16'h0007);

    // JZ taken after ADD gives zero.
    p = '{8'h14, 8'h70, 8'h10, 8'h00};
    applyStimulus(p);
    memA[16'h0010] = 8'hF0;
    expectTxn(1'b0, 20'h0, 16'h0, 1'b0, 0);
    expectTxn(1'b0, 20'h1, 16'h0, 1'b1, 0);
    expectReads(20'h2, 2);
    expectTxn(1'b0, 20'h10, 16'h0, 1'b0, 4);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 200);
    checkFinalA("jzTaken", 8'h00, 2'b01, 16'h0011);

    // JZ not taken with a nonzero ADD result.
    p = '{8'h21, 8'h01, 8'h30, 8'h14, 8'h70, 8'h10, 8'h00, 8'hF0};
    applyStimulus(p);
    memA[16'h0010] = 8'hF0;
    expectReads(20'h0, 4);
    expectTxn(1'b0, 20'h4, 16'h0, 1'b1, 0);
    expectReads(20'h5, 2);
    expectTxn(1'b0, 20'h7, 16'h0, 1'b0, 4);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 200);
    checkFinalA("jzNotTaken", 8'h02, 2'b00, 16'h0008);

    // ST then LD through a memory with two wait states per access.
    waitCfg = 2;
    p = '{8'h21, 8'hA5, 8'h50, 8'h00, 8'h02, 8'h40, 8'h00, 8'h02, 8'hF0};
    applyStimulus(p);
    expectTxn(1'b0, 20'h0, 16'h0, 1'b0, 0);
    expectTxn(1'b0, 20'h1, 16'h0, 1'b1, 0);
    expectReads(20'h2, 3);
    expectTxn(1'b1, 20'h200, 16'h00A5, 1'b0, 5 + 2 * 4);
    expectTxn(1'b0, 20'h5, 16'h0, 1'b1, 0);
    expectReads(20'h6, 2);
    expectTxn(1'b0, 20'h200, 16'h0, 1'b0, 0);
    expectTxn(1'b0, 20'h8, 16'h0, 1'b0, 5 + 2 * 4);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 400);
    checkFinalA("ldst", 8'hA5, 2'b00, 16'h0009);
    checkOutput("ldst.mem200", {24'h0, memA[16'h0200]}, 32'hA5);
    waitCfg = 0;

    // Shifts and subtract borrow.
    p = '{8'h21, 8'h81, 8'h18, 8'hF0};
    applyStimulus(p);
    expectReads(20'h0, 4);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 200);
    checkFinalA("ashr", 8'hC0, 2'b10, 16'h0004);

    p = '{8'h21, 8'h01, 8'h17, 8'hF0};
    applyStimulus(p);
    expectReads(20'h0, 4);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 200);
    checkFinalA("lshr", 8'h00, 2'b11, 16'h0004);

    p = '{8'h21, 8'h03, 8'h30, 8'h21, 8'h01, 8'h15, 8'hF0};
    applyStimulus(p);
    expectReads(20'h0, 7);
    @(negedge clk);
    rstA = 1'b0;
    waitHalted(1'b0, 200);
    checkFinalA("sub", 8'hFE, 2'b10, 16'h0007);

    // Wide core: two-word jumps and PC wrap from the top of the address space.
    rstA = 1'b1;
    memB[20'h00010] = 12'h060;
    memB[20'h00011] = 12'h345;
    memB[20'h00012] = 12'h0AB;
    memB[20'hAB345] = 12'h060;
    memB[20'hAB346] = 12'hFFF;
    memB[20'hAB347] = 12'h0FF;
    memB[20'hFFFFF] = 12'h000;
    memB[20'h00000] = 12'h0F0;
    expectTxn(1'b0, 20'h00010, 16'h0, 1'b1, 0);
    expectReads(20'h00011, 2);
    expectTxn(1'b0, 20'hAB345, 16'h0, 1'b0, 4);
    expectReads(20'hAB346, 2);
    expectTxn(1'b0, 20'hFFFFF, 16'h0, 1'b0, 0);
    expectTxn(1'b0, 20'h00000, 16'h0, 1'b0, 0);
    @(negedge clk);
    checkOutput("rstB.pc", {12'h0, pcB}, 32'h00010);
    rstB = 1'b0;
    waitHalted(1'b1, 200);
    checkOutput("wide.pc", {12'h0, pcB}, 32'h00001);
    checkOutput("wide.acc", {20'h0, accB}, 32'h0);
    checkOutput("wide.queueEmpty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
